axi_master_dm: RTL
==================

Name: axi_master_dm

Overview:
- AXI4 single-beat master bridge between the CPU data-memory port and the AXI interconnect.
- Converts CPU SRAM-style requests (req, byte-lane WEB, addr, wdata) into AR/R or AW/W/B transactions toward slave_dm-based SRAM wrappers.
- Returns read data plus a one-cycle completion pulse to the core.
- One outstanding transaction at a time; no bursts.

Parameters:
- MASTER_ID, 4'd1, value driven on AWID and ARID.
- ADDR_W, 32, AXI/core address width.
- DATA_W, 32, AXI/core data width; STRB is DATA_W/8.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- core_req  in  1  request; held high with stable fields until core_done.
- core_web  in  4  active-low byte write enables; 4'hF = read, anything else = write.
- core_addr  in  ADDR_W  byte address.
- core_wdata  in  DATA_W  write data.
- core_rdata  out  DATA_W  read data; valid in the core_done cycle of a read.
- core_done  out  1  one-cycle completion pulse.
- core_busy  out  1  high from request acceptance until core_done.
- core_err  out  1  response error flag (see Optional Feature).
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  4/ADDR_W/4/3/2  write address fields.
- AWVALID out 1; AWREADY in 1.
- WDATA/WSTRB/WLAST  out  DATA_W/4/1  write data fields.
- WVALID out 1; WREADY in 1.
- BID/BRESP  in  4/2  write response; BVALID in 1; BREADY out 1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  4/ADDR_W/4/3/2  read address fields.
- ARVALID out 1; ARREADY in 1.
- RID/RDATA/RRESP/RLAST  in  4/DATA_W/2/1  read data; RVALID in 1; RREADY out 1.

Behaviour:
- Constants: AxLEN=4'd0, AxSIZE=3'b010, AxBURST=2'b01 (INCR), WLAST=1. AxID=MASTER_ID. AxADDR = latched address with bits [1:0] forced to 0.
- Reset values: all VALID/READY outputs, core_done, core_busy and core_err are 0; core_rdata is 0; state is IDLE.
- FSM states: IDLE, RADDR, RDATA, WADDR, WRESP.
- IDLE:
  - A request is accepted when core_req=1 and core_done=0.
  - On accept, latch addr, wdata and WSTRB=~core_web.
  - core_web==4'hF: go to RADDR. Otherwise: go to WADDR.
- RADDR: ARVALID=1 until ARREADY is sampled high, then go to RDATA.
- RDATA: RREADY=1. On RVALID: latch RDATA into core_rdata, pulse core_done next cycle, go to IDLE. RID and RLAST are ignored.
- WADDR:
  - AWVALID and WVALID both assert on entry.
  - Each deasserts independently after its own handshake; internal aw_done and w_done flags track this.
  - Both handshakes may land in the same cycle.
  - When both are done, go to WRESP.
- WRESP: BREADY=1. On BVALID: pulse core_done next cycle, go to IDLE.
- While VALID=1 and READY=0, all payload signals on that channel are held stable. A VALID is never withdrawn before its handshake.
- Minimum latency with zero-wait slave (request sampled at edge T):
  - Read: ARVALID at T+1; RREADY at T+2; core_done and core_rdata at T+3.
  - Write: AWVALID and WVALID at T+1; BREADY at T+2; core_done at T+3.
- Back-to-back: core_req is ignored in the core_done cycle; the next request is accepted at the earliest one cycle after core_done.
- core_busy = (state != IDLE).
- core_rdata holds its value until the next read completes.
- A write leaves core_rdata unchanged.
- Reset mid-transaction: all outputs return to reset values at the next edge and the transaction is abandoned. The interconnect and slaves must share the same reset.
- core_web or core_addr changing while core_busy is ignored, because latched copies are used.

Optional Feature:
- Macro: AXI_MASTER_RESP_CHECK_EN.
- Defined:
  - core_err is registered and asserts with core_done when the completing RRESP or BRESP is non-zero (SLVERR/DECERR).
  - core_err also asserts when the RID/BID returned differs from MASTER_ID.
  - core_err clears on the next cycle.
- Undefined: core_err is tied 0 and the response/ID fields are unused.

Test Plan:
- Zero-wait read: core_web=4'hF, addr=32'h0001_0006, RDATA=32'hDEAD_BEEF.
  - ARADDR=32'h0001_0004 and ARVALID at T+1; core_done and core_rdata=32'hDEADBEEF at T+3.
- Byte write: core_web=4'b1110, wdata=32'h1234_5678.
  - WSTRB=4'b0001, WLAST=1, AWLEN=0, AWSIZE=3'b010; core_done at T+3.
- Split write handshakes: AWREADY delayed 3 cycles, WREADY immediate.
  - WVALID drops after 1 cycle, AWVALID held with stable AWADDR, WRESP entered only after AW.
- Backpressure read: ARREADY low for 4 cycles, RVALID delayed 2 further cycles.
  - ARVALID and ARADDR stable throughout; exactly one core_done pulse.
- Reset mid-write: ARESET=1 during WRESP.
  - Next edge: BREADY=0, core_busy=0, core_done=0. Afterwards a read completes normally.
- With AXI_MASTER_RESP_CHECK_EN: BRESP=2'b10.
  - core_err=1 for exactly the core_done cycle; without the macro, core_err stays 0.

Source files
------------

// File: rtl/axi_master_dm.sv
// -----------------------------------------------------------------------------
// axi_master_dm
//   Single-beat AXI4 master bridge for the CPU data-memory port. A held
//   SRAM-style request (core_req + byte-lane write enables) becomes either an
//   AR/R read or an AW/W/B write. Only one transaction is in flight at a time.
//   The core sees read data and a one-cycle done pulse when it completes.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   core_req/web/addr/wdata   request from the core (web 4'hF = read)
//   core_rdata/done/busy/err  completion data, pulse, busy flag, error flag
//   AW*, W*, B*            AXI write address / data / response channels
//   AR*, R*                AXI read address / data channels
//
// Optional feature macro: AXI_MASTER_RESP_CHECK_EN
//   When defined, core_err pulses with core_done if the completing RRESP/BRESP
//   is non-zero or the returned RID/BID differs from MASTER_ID.
//   When undefined, core_err is tied low.
// -----------------------------------------------------------------------------
module axi_master_dm #(
  parameter logic [3:0] MASTER_ID = 4'd1,
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // core side
  input  logic                core_req,
  input  logic [DATA_W/8-1:0] core_web,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_done,
  output logic                core_busy,
  output logic                core_err,
  // write address
  output logic [3:0]          AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  // write data
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  // write response
  input  logic [3:0]          BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  // read address
  output logic [3:0]          ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [3:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  // read data
  input  logic [3:0]          RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WRESP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-3:0]     addr_q, addr_d;      // word address; byte offset dropped
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;

  logic                  rd_bad;
  logic                  wr_bad;
  logic                  aw_now;
  logic                  w_now;

`ifdef AXI_MASTER_RESP_CHECK_EN
  assign rd_bad = (RRESP != 2'b00) || (RID != MASTER_ID);
  assign wr_bad = (BRESP != 2'b00) || (BID != MASTER_ID);
  logic unused_sig;
  assign unused_sig = ^{RLAST, core_addr[1:0]};
`else
  assign rd_bad = 1'b0;
  assign wr_bad = 1'b0;
  logic unused_sig;
  assign unused_sig = ^{RLAST, core_addr[1:0], RID, RRESP, BID, BRESP};
`endif

  // A channel counts as done once its handshake has happened, either in an
  // earlier cycle (sticky flag) or in this one.
  assign aw_now = aw_done_q | (awvalid_q & AWREADY);
  assign w_now  = w_done_q  | (wvalid_q  & WREADY);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      S_IDLE: begin
        // done_q blocks re-acceptance of the request that just completed
        if (core_req && !done_q) begin
          addr_d  = core_addr[ADDR_W-1:2];
          wdata_d = core_wdata;
          wstrb_d = ~core_web;
          if (core_web == {STRB_W{1'b1}}) begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end else begin
            state_d   = S_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
        end
      end
      S_RADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (RVALID) begin
          rready_d = 1'b0;
          rdata_d  = RDATA;
          done_d   = 1'b1;
          err_d    = rd_bad;
          state_d  = S_IDLE;
        end
      end
      S_WADDR: begin
        aw_done_d = aw_now;
        w_done_d  = w_now;
        if (aw_now) awvalid_d = 1'b0;
        if (w_now)  wvalid_d  = 1'b0;
        if (aw_now && w_now) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (BVALID) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = wr_bad;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign core_rdata = rdata_q;
  assign core_done  = done_q;
  assign core_busy  = (state_q != S_IDLE);
  assign core_err   = err_q;

  assign AWID    = MASTER_ID;
  assign AWADDR  = {addr_q, 2'b00};
  assign AWLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = awvalid_q;

  assign WDATA  = wdata_q;
  assign WSTRB  = wstrb_q;
  assign WLAST  = 1'b1;
  assign WVALID = wvalid_q;

  assign BREADY = bready_q;

  assign ARID    = MASTER_ID;
  assign ARADDR  = {addr_q, 2'b00};
  assign ARLEN   = 4'd0;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign ARVALID = arvalid_q;

  assign RREADY = rready_q;

endmodule
